rx_lane_release_ctrl: RTL and testbench



---
 rtl/rx_lane_release_ctrl_if.sv | 30 +++
 rtl/rx_lane_release_ctrl.sv | 159 +++++++++++++++
 tb/tb_rx_lane_release_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rx_lane_release_ctrl_if.sv
// Link-controller and lane-buffer side signals of rx_lane_release_ctrl.
// master drives the link/lane inputs, slave is the release controller itself.
interface rx_lane_release_ctrl_if #(
    parameter int L      = 1,
    parameter int RBD_W  = 8,
    parameter int TMO_W  = 8,
    parameter int SKEW_W = 8
);
    logic [L-1:0]      lane_disable_i;
    logic [L-1:0]      ifs_rst_i;
    logic [L-1:0]      lane_ilas_start_i;
    logic              lmfc_clk_i;
    logic [RBD_W-1:0]  rbd_i;
    logic [TMO_W-1:0]  tmo_i;
    logic [L-1:0]      buf_release_o;
    logic              released_o;
    logic              timeout_o;
    logic              relink_req_o;
    logic [SKEW_W-1:0] skew_o;

    modport master (
        output lane_disable_i, ifs_rst_i, lane_ilas_start_i, lmfc_clk_i, rbd_i, tmo_i,
        input  buf_release_o, released_o, timeout_o, relink_req_o, skew_o
    );

    modport slave (
        input  lane_disable_i, ifs_rst_i, lane_ilas_start_i, lmfc_clk_i, rbd_i, tmo_i,
        output buf_release_o, released_o, timeout_o, relink_req_o, skew_o
    );
endinterface

// File: rtl/rx_lane_release_ctrl.sv
// JESD204B subclass-1 elastic-buffer release sequencer: waits for all enabled lanes,
// then releases every buffer rbd cycles after an LMFC boundary. Skew monitor under JESD_RX_SKEW_MON_EN.
module rx_lane_release_ctrl #(
    parameter int L      = 1,
    parameter int RBD_W  = 8,
    parameter int TMO_W  = 8,
    parameter int SKEW_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    rx_lane_release_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_LANES,
        ST_WAIT_LMFC,
        ST_DELAY,
        ST_RELEASED,
        ST_ERROR
    } state_e;

    state_e           state_q, state_d;
    logic [L-1:0]     mask_q, seen_q, seen_d, enabled;
    logic [RBD_W-1:0] dly_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_inc;
    logic             idle_go, idle_exit, ifs_hit, ifs_all, all_seen;
    logic             tmo_hit, rbd_zero, counting;
    logic [L-1:0]     buf_release_d, buf_release_q;
    logic             released_d, released_q;
    logic             timeout_d, timeout_q;
    logic             relink_d, relink_q;

    // In IDLE the live disable vector decides; afterwards only the captured mask counts.
    assign enabled     = ~mask_q;
    assign idle_go     = ~|(bus.ifs_rst_i & ~bus.lane_disable_i) && |(~bus.lane_disable_i);
    assign idle_exit   = (state_q == ST_IDLE) && idle_go;
    assign ifs_hit     = |(bus.ifs_rst_i & enabled);
    assign ifs_all     = &(bus.ifs_rst_i | mask_q);
    assign seen_d      = seen_q | (bus.lane_ilas_start_i & enabled);
    assign all_seen    = &(seen_d | mask_q);
    assign rbd_zero    = (bus.rbd_i == '0);
    assign counting    = (state_q == ST_WAIT_LANES) || (state_q == ST_WAIT_LMFC) ||
                         (state_q == ST_DELAY);
    assign tmo_cnt_inc = (&tmo_cnt_q) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
    assign tmo_hit     = bus.lmfc_clk_i && (bus.tmo_i != '0) && (tmo_cnt_inc >= bus.tmo_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // A lane IFS reset always wins; release beats timeout only where both land together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (idle_go) state_d = ST_WAIT_LANES;
            end
            ST_WAIT_LANES: begin
                if (ifs_hit)       state_d = ST_IDLE;
                else if (tmo_hit)  state_d = ST_ERROR;
                else if (all_seen) state_d = ST_WAIT_LMFC;
            end
            ST_WAIT_LMFC: begin
                if (ifs_hit)                           state_d = ST_IDLE;
                else if (bus.lmfc_clk_i && rbd_zero)   state_d = ST_RELEASED;
                else if (tmo_hit)                      state_d = ST_ERROR;
                else if (bus.lmfc_clk_i)               state_d = ST_DELAY;
            end
            ST_DELAY: begin
                if (ifs_hit) state_d = ST_IDLE;
                else if (bus.lmfc_clk_i) begin
                    if (rbd_zero)     state_d = ST_RELEASED;
                    else if (tmo_hit) state_d = ST_ERROR;
                end
                else if (dly_cnt_q == '0) state_d = ST_RELEASED;
            end
            ST_RELEASED: begin
                if (ifs_hit) state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (ifs_all) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output comes straight off a flop.
    always_comb begin
        buf_release_d = '0;
        released_d    = 1'b0;
        relink_d      = 1'b0;
        timeout_d     = timeout_q;
        if (state_d == ST_RELEASED) begin
            buf_release_d = enabled;
            released_d    = 1'b1;
        end
        if ((state_q == ST_RELEASED) && (state_d == ST_IDLE)) relink_d = 1'b1;
        if ((state_q != ST_ERROR) && (state_d == ST_ERROR)) begin
            relink_d  = 1'b1;
            timeout_d = 1'b1;
        end
        if (idle_exit) timeout_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q        <= '0;
            seen_q        <= '0;
            dly_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            buf_release_q <= '0;
            released_q    <= 1'b0;
            timeout_q     <= 1'b0;
            relink_q      <= 1'b0;
        end else begin
            if (idle_exit) begin
                mask_q <= bus.lane_disable_i;
                seen_q <= '0;
            end else if (state_q == ST_WAIT_LANES) begin
                seen_q <= seen_d;
            end
            if (idle_exit)                         tmo_cnt_q <= '0;
            else if (counting && bus.lmfc_clk_i)   tmo_cnt_q <= tmo_cnt_inc;
            // Every LMFC boundary seen while waiting or delaying restarts the delay.
            if (((state_q == ST_WAIT_LMFC) || (state_q == ST_DELAY)) && bus.lmfc_clk_i)
                dly_cnt_q <= bus.rbd_i - RBD_W'(1);
            else if ((state_q == ST_DELAY) && (dly_cnt_q != '0))
                dly_cnt_q <= dly_cnt_q - RBD_W'(1);
            buf_release_q <= buf_release_d;
            released_q    <= released_d;
            timeout_q     <= timeout_d;
            relink_q      <= relink_d;
        end
    end

    assign bus.buf_release_o = buf_release_q;
    assign bus.released_o    = released_q;
    assign bus.timeout_o     = timeout_q;
    assign bus.relink_req_o  = relink_q;

`ifdef JESD_RX_SKEW_MON_EN
    logic [SKEW_W-1:0] skew_q;

    // Counts from the cycle after the first lane is seen until the last one arrives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            skew_q <= '0;
        else if (idle_exit)
            skew_q <= '0;
        else if ((state_q == ST_WAIT_LANES) && |seen_q && !(&(seen_q | mask_q)) && !(&skew_q))
            skew_q <= skew_q + SKEW_W'(1);
    end

    assign bus.skew_o = skew_q;
`else
    assign bus.skew_o = {SKEW_W{1'b0}};
`endif
endmodule

// File: tb/tb_rx_lane_release_ctrl.sv
// Randomized bench for rx_lane_release_ctrl: expected release, timeout and skew timing
// is derived from lane start times and the LMFC schedule of each bring-up.
module tb_rx_lane_release_ctrl;
    localparam int L      = 4;
    localparam int RBD_W  = 8;
    localparam int TMO_W  = 8;
    localparam int SKEW_W = 8;
    localparam int P      = 16;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   n_checks = 0;
    int   n_fails  = 0;
    bit   timeout_carry = 1'b0;

    rx_lane_release_ctrl_if #(.L(L), .RBD_W(RBD_W), .TMO_W(TMO_W), .SKEW_W(SKEW_W)) bus ();

    rx_lane_release_ctrl #(.L(L), .RBD_W(RBD_W), .TMO_W(TMO_W), .SKEW_W(SKEW_W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int next_pulse(input int from, input int ph);
        return from + ((ph - (from % P) + P) % P);
    endfunction

    // One bring-up: IFS reset drops at c0, enabled lanes start at s[i], teardown at x_end.
    // abort_mode 1 pulls reset mid-DELAY, 2 pulls it while released.
    task automatic apply_stimulus(input logic [L-1:0] mask, input int rbd, input int tmo,
                                  input int abort_mode);
        int s[L];
        int c0, ph, first, last, t_lmfc, q_tmo, r_rel, x_end, exp_skew, kill, off, abort_at;
        bit rel, tmo_ev, skew_ok;
        logic [L-1:0] st, exp_buf;
        bit exp_rel, exp_relink, exp_tmo;

        ph    = $urandom_range(0, P - 1);
        c0    = $urandom_range(3, 10);
        first = 1 << 30;
        last  = 0;
        for (int i = 0; i < L; i++) begin
            s[i] = c0 + 1 + $urandom_range(0, 12);
            if (!mask[i]) begin
                if (s[i] < first) first = s[i];
                if (s[i] > last)  last  = s[i];
            end
        end
        exp_skew = last - first;
        t_lmfc   = next_pulse(last + 1, ph);
        q_tmo    = next_pulse(c0 + 1, ph) + (tmo - 1) * P;
        r_rel    = t_lmfc + rbd + 1;
        rel      = (rbd < P);
        tmo_ev   = (tmo != 0) && (!rel || (q_tmo < r_rel - 1));
        if (tmo_ev) rel = 1'b0;
        if (rel)         x_end = r_rel + $urandom_range(2, 8);
        else if (tmo_ev) x_end = q_tmo + 1 + $urandom_range(1, 6);
        else             x_end = last + 40 + $urandom_range(0, 10);
        skew_ok  = !(tmo_ev && (q_tmo <= last));
        abort_at = (abort_mode == 1) ? t_lmfc + 3 : (abort_mode == 2) ? r_rel + 2 : -1;
        off  = $urandom_range(0, L - 1);
        kill = 0;
        for (int k = L - 1; k >= 0; k--)
            if (!mask[(off + k) % L]) kill = (off + k) % L;

        bus.rbd_i = RBD_W'(rbd);
        bus.tmo_i = TMO_W'(tmo);
        for (int c = 0; c <= x_end + 4; c++) begin
            bus.lmfc_clk_i = ((c % P) == ph);
            if (c < c0)                   bus.ifs_rst_i = '1;
            else if (c < x_end)           bus.ifs_rst_i = mask & L'($urandom);
            else if (c == x_end && rel)   bus.ifs_rst_i = (mask & L'($urandom)) | (L'(1) << kill);
            else                          bus.ifs_rst_i = '1;
            bus.lane_disable_i = (c > c0 && c < x_end) ? L'($urandom) : mask;
            for (int i = 0; i < L; i++)
                st[i] = mask[i] ? 1'($urandom) : ((c >= s[i]) && (c <= x_end));
            bus.lane_ilas_start_i = st;

            @(negedge clk_i);
            exp_rel    = rel && (c >= r_rel) && (c <= x_end);
            exp_buf    = exp_rel ? ~mask : '0;
            exp_relink = (rel && (c == x_end + 1)) || (tmo_ev && (c == q_tmo + 1));
            exp_tmo    = (timeout_carry && (c <= c0)) || (tmo_ev && (c >= q_tmo + 1));
            check_output("buf_release", 32'(bus.buf_release_o), 32'(exp_buf));
            check_output("released", 32'(bus.released_o), 32'(exp_rel));
            check_output("relink_req", 32'(bus.relink_req_o), 32'(exp_relink));
            check_output("timeout", 32'(bus.timeout_o), 32'(exp_tmo));
`ifdef JESD_RX_SKEW_MON_EN
            if (skew_ok && (c > last))
                check_output("skew", 32'(bus.skew_o), 32'(exp_skew));
`else
            if (skew_ok || exp_skew >= 0)
                check_output("skew_off", 32'(bus.skew_o), 32'd0);
`endif
            if (c == abort_at) begin
                #2 rst_ni = 1'b0;
                #1;
                check_output("rst_buf_release", 32'(bus.buf_release_o), 32'd0);
                check_output("rst_released", 32'(bus.released_o), 32'd0);
                check_output("rst_timeout", 32'(bus.timeout_o), 32'd0);
                check_output("rst_relink", 32'(bus.relink_req_o), 32'd0);
                check_output("rst_skew", 32'(bus.skew_o), 32'd0);
                bus.ifs_rst_i      = '1;
                bus.lmfc_clk_i     = 1'b0;
                bus.lane_disable_i = mask;
                @(posedge clk_i);
                #1 rst_ni = 1'b1;
                timeout_carry = 1'b0;
                return;
            end
            @(posedge clk_i);
            #1;
        end
        timeout_carry = tmo_ev;
    endtask

    initial begin
        rst_ni                = 1'b0;
        bus.ifs_rst_i         = '1;
        bus.lane_disable_i    = '0;
        bus.lane_ilas_start_i = '0;
        bus.lmfc_clk_i        = 1'b0;
        bus.rbd_i             = '0;
        bus.tmo_i             = '0;
        #12;
        check_output("reset_buf_release", 32'(bus.buf_release_o), 32'd0);
        check_output("reset_released", 32'(bus.released_o), 32'd0);
        check_output("reset_timeout", 32'(bus.timeout_o), 32'd0);
        check_output("reset_relink", 32'(bus.relink_req_o), 32'd0);
        check_output("reset_skew", 32'(bus.skew_o), 32'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        $display("[TB] directed bring-ups");
        apply_stimulus(4'b0000, 5, 0, 0);
        apply_stimulus(4'b0100, 0, 0, 0);
        apply_stimulus(4'b0000, 20, 3, 0);
        apply_stimulus(4'b0010, 4, 0, 0);
        apply_stimulus(4'b0000, 20, 0, 1);
        apply_stimulus(4'b1000, 2, 0, 2);
        apply_stimulus(4'b0000, 15, 2, 0);

        $display("[TB] randomized bring-ups");
        for (int n = 0; n < 30; n++)
            apply_stimulus(L'($urandom_range(0, 14)), $urandom_range(0, 20),
                           $urandom_range(0, 5), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
